mult_seq: RTL and testbench

Sequential signed shift-add multiplier feeding the LED output stage. Accepts two DW-bit two's-complement operands on a one-cycle start pulse and produces the DW2-bit unsigned magnitude of the product plus a separate sign bit. Raises a completion flag that the LED stage uses to gate the display. Fixed latency of DW cycles; one multiplication in flight at a time.

---
 rtl/mult_seq_pkg.sv | 39 +++
 rtl/mult_ctrl.sv | 72 +++++++
 rtl/mult_seq.sv | 80 ++++++++
 tb/tb_mult_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// pkg_mult: shared widths, types and helpers for the sequential signed
// shift-add multiplier (mult_seq) and its controller (mult_ctrl).
//   DW      operand width in bits
//   DW2     product magnitude width in bits
//   CW      cycle counter width
package pkg_mult;

  localparam int DW  = 8;
  localparam int DW2 = 2 * DW;
  localparam int CW  = $clog2(DW);

  typedef logic [DW-1:0]  operand_t;
  typedef logic [DW2-1:0] product_t;
  typedef logic [DW2:0]   leds_t;
  typedef logic [CW-1:0]  count_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MULT = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam operand_t OP_ONE   = {{(DW-1){1'b0}}, 1'b1};
  localparam count_t   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam count_t   CNT_LAST = {CW{1'b1}};  // DW-1 (DW is a power of two)

  // Two's-complement magnitude as an unsigned DW-bit value. The most
  // negative operand maps to 2^(DW-1), which still fits unsigned.
  function automatic operand_t abs_mag(input operand_t x);
    operand_t r;
    if (x[DW-1]) begin
      r = ~x + OP_ONE;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_ctrl.sv
// mult_ctrl: FSM and cycle counter for mult_seq.
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous reset, active-low
//   i_start  start pulse (honoured in IDLE and DONE, ignored in MULT)
//   load     datapath loads operands this edge
//   shift    datapath performs one add/shift step this edge (state MULT)
//   done_en  result is complete and held (state DONE)
module mult_ctrl
  import pkg_mult::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  output logic load,
  output logic shift,
  output logic done_en
);

  state_e state_r;
  state_e state_nxt_s;
  count_t cnt_r;
  count_t cnt_nxt_s;
  logic   load_s;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state, counter update and load strobe.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    load_s      = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (i_start) begin
          load_s      = 1'b1;
          cnt_nxt_s   = '0;
          state_nxt_s = MULT;
        end else begin
          state_nxt_s = state_r;
        end
      end
      MULT: begin
        // i_start is deliberately not looked at here.
        cnt_nxt_s = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = MULT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  assign load    = load_s;
  assign shift   = (state_r == MULT);
  assign done_en = (state_r == DONE);

endmodule

// File: rtl/mult_seq.sv
// mult_seq: sequential signed shift-add multiplier. Converts both operands
// to magnitudes, multiplies over DW cycles, and reports |A*B| with a
// separate sign bit.
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous reset, active-low
//   i_start         one-cycle start pulse, operands sampled on the same edge
//   i_multiplicand  two's-complement operand A
//   i_multiplier    two's-complement operand B
//   o_product       |A*B|, valid while o_stop=1
//   o_sign          1 = negative product, valid while o_stop=1
//   o_stop          result ready
//   o_busy          multiplication in progress
module mult_seq
  import pkg_mult::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     i_start,
  input  operand_t i_multiplicand,
  input  operand_t i_multiplier,
  output product_t o_product,
  output logic     o_sign,
  output logic     o_stop,
  output logic     o_busy
);

  logic     load_s;
  logic     shift_s;
  logic     done_en_s;
  product_t acc_r;
  product_t mcand_r;
  operand_t mplier_r;
  logic     sign_r;

  mult_ctrl u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .load    (load_s),
    .shift   (shift_s),
    .done_en (done_en_s)
  );

  // Operand shift registers, accumulator and sign capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      sign_r   <= 1'b0;
    end else if (load_s) begin
      acc_r    <= '0;
      mcand_r  <= {{DW{1'b0}}, abs_mag(i_multiplicand)};
      mplier_r <= abs_mag(i_multiplier);
      sign_r   <= i_multiplicand[DW-1] ^ i_multiplier[DW-1];
    end else if (shift_s) begin
      // Magnitudes are at most 2^(DW-1) so the DW2-bit sum never overflows.
      if (mplier_r[0]) begin
        acc_r <= acc_r + mcand_r;
      end else begin
        acc_r <= acc_r;
      end
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
    end else begin
      acc_r    <= acc_r;
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
      sign_r   <= sign_r;
    end
  end

  assign o_product = acc_r;
  // A zero result is never reported as negative.
  assign o_sign    = sign_r & (acc_r != '0);
  assign o_stop    = done_en_s;
  assign o_busy    = shift_s;

endmodule

// File: tb/tb_mult_seq.sv
module tb_mult_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  a = 8'h00;
  logic [7:0]  b = 8'h00;
  logic [15:0] o_product;
  logic        o_sign;
  logic        o_stop;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  mult_seq dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_multiplicand (a),
    .i_multiplier   (b),
    .o_product      (o_product),
    .o_sign         (o_sign),
    .o_stop         (o_stop),
    .o_busy         (o_busy)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are then stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle start pulse; returns 1 ns after the accepting edge t0.
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
    a = av;
    b = bv;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if ({o_product, o_sign, o_stop, o_busy} !== 19'd0) begin
      errors++;
      $display("FAIL reset_hold: prod=%0d sign=%b stop=%b busy=%b, expected all 0",
               o_product, o_sign, o_stop, o_busy);
    end
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if ({o_product, o_sign, o_stop, o_busy} !== 19'd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: prod=%0d sign=%b stop=%b busy=%b, expected all 0",
                 c, o_product, o_sign, o_stop, o_busy);
      end
    end
  endtask

  // 5 * -3 = -15, with cycle-exact latency check.
  task automatic test_basic();
    start_op(8'h05, 8'hFD);
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (o_stop !== 1'b0 || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_latency t0+%0d: stop=%b busy=%b, expected stop=0 busy=1",
                 c, o_stop, o_busy);
      end
      tick();
    end
    checks++;
    if (o_stop !== 1'b1 || o_busy !== 1'b0 || o_product !== 16'd15 || o_sign !== 1'b1) begin
      errors++;
      $display("FAIL basic_result: stop=%b busy=%b prod=%0d sign=%b, expected 1 0 15 1",
               o_stop, o_busy, o_product, o_sign);
    end
    repeat (3) tick();
    checks++;
    if (o_stop !== 1'b1 || o_product !== 16'd15 || o_sign !== 1'b1) begin
      errors++;
      $display("FAIL basic_hold: stop=%b prod=%0d sign=%b, expected 1 15 1",
               o_stop, o_product, o_sign);
    end
  endtask

  // -128 * -128 then 127 * 127 restarted in the first DONE cycle.
  task automatic test_extremes();
    start_op(8'h80, 8'h80);
    repeat (8) tick();
    checks++;
    if (o_stop !== 1'b1 || o_product !== 16'd16384 || o_sign !== 1'b0) begin
      errors++;
      $display("FAIL min_by_min: stop=%b prod=%0d sign=%b, expected 1 16384 0",
               o_stop, o_product, o_sign);
    end
    start_op(8'h7F, 8'h7F);
    checks++;
    if (o_stop !== 1'b0 || o_busy !== 1'b1 || o_product !== 16'd0) begin
      errors++;
      $display("FAIL restart_clear: stop=%b busy=%b prod=%0d, expected 0 1 0",
               o_stop, o_busy, o_product);
    end
    repeat (8) tick();
    checks++;
    if (o_stop !== 1'b1 || o_product !== 16'd16129 || o_sign !== 1'b0) begin
      errors++;
      $display("FAIL max_by_max: stop=%b prod=%0d sign=%b, expected 1 16129 0",
               o_stop, o_product, o_sign);
    end
  endtask

  // Zero rule plus a few more signed combinations.
  task automatic test_vectors();
    logic [7:0]  va [4] = '{8'h00, 8'h7F, 8'hFF, 8'hF6};
    logic [7:0]  vb [4] = '{8'hF9, 8'h80, 8'hFF, 8'h0B};
    logic [15:0] vp [4] = '{16'd0, 16'd16256, 16'd1, 16'd110};
    logic        vs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i]);
      repeat (8) tick();
      checks++;
      if (o_stop !== 1'b1 || o_product !== vp[i] || o_sign !== vs[i]) begin
        errors++;
        $display("FAIL vector %0d (%h*%h): stop=%b prod=%0d sign=%b, expected 1 %0d %b",
                 i, va[i], vb[i], o_stop, o_product, o_sign, vp[i], vs[i]);
      end
    end
  endtask

  // A start pulse during MULT must be ignored.
  task automatic test_ignore_start();
    start_op(8'h03, 8'h04);
    repeat (2) tick();
    a = 8'h09;
    b = 8'h09;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (4) tick();
    checks++;
    if (o_stop !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_pre: stop=%b busy=%b at t0+7, expected 0 1", o_stop, o_busy);
    end
    tick();
    checks++;
    if (o_stop !== 1'b1 || o_product !== 16'd12 || o_sign !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result: stop=%b prod=%0d sign=%b, expected 1 12 0",
               o_stop, o_product, o_sign);
    end
  endtask

  // Reset in the middle of a multiplication, then a clean restart.
  task automatic test_reset_mid();
    start_op(8'hFA, 8'h07);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({o_product, o_sign, o_stop, o_busy} !== 19'd0) begin
      errors++;
      $display("FAIL midreset_async: prod=%0d sign=%b stop=%b busy=%b, expected all 0",
               o_product, o_sign, o_stop, o_busy);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({o_product, o_sign, o_stop, o_busy} !== 19'd0) begin
      errors++;
      $display("FAIL midreset_idle: prod=%0d sign=%b stop=%b busy=%b, expected all 0",
               o_product, o_sign, o_stop, o_busy);
    end
    start_op(8'h02, 8'h02);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_accept: busy=%b, expected 1", o_busy);
    end
    repeat (8) tick();
    checks++;
    if (o_stop !== 1'b1 || o_product !== 16'd4 || o_sign !== 1'b0) begin
      errors++;
      $display("FAIL midreset_result: stop=%b prod=%0d sign=%b, expected 1 4 0",
               o_stop, o_product, o_sign);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_vectors();
    test_ignore_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
